// File: rtl/le_window_scheduler_pkg.sv
// le_window_scheduler_pkg
// Shared definitions for the Le window scheduler slice.
// Contents:
//   - default widths, mirroring the decoder-wide width defines
//   - block-length limits and the pipeline-flush gap length
//   - the scheduler FSM state encoding
package le_window_scheduler_pkg;

    localparam int LE_WINDOW_WIDTH = 9;
    localparam int LE_ADDR_WIDTH   = 13;
    localparam int LE_CMP_WIDTH    = 13;
    localparam int LE_ITER_WIDTH   = 4;

    localparam int LE_BLK_MIN    = 4;
    localparam int LE_BLK_MAX    = 6144;
    localparam int LE_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } le_state_t;

endpackage

// File: rtl/le_window_scheduler_if.sv
// le_window_scheduler_if
// Bundles the decoder-control handshake and the scheduler outputs.
// Signals:
//   start, blockSize, numIter       - run request from decoder control
//   busy, done, err                 - run status
//   CmpCounter, r, q_up, halfIter   - symbol counter, window split, pass index
//   cap_f, cap_g                    - init-address capture strobes
//   buf_wr_sel, buf_rd_sel          - window buffer selects
// Modports:
//   master - the decoder-control side (drives the request)
//   slave  - the scheduler side (drives status and sequencing outputs)
interface le_window_scheduler_if
    import le_window_scheduler_pkg::*;
#(
    parameter int WINDOW_WIDTH = LE_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = LE_ADDR_WIDTH,
    parameter int CMP_WIDTH    = LE_CMP_WIDTH,
    parameter int ITER_WIDTH   = LE_ITER_WIDTH
);

    logic                    start;
    logic [ADDR_WIDTH-1:0]   blockSize;
    logic [ITER_WIDTH-1:0]   numIter;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [CMP_WIDTH-1:0]    CmpCounter;
    logic [WINDOW_WIDTH-1:0] r;
    logic [3:0]              q_up;
    logic [ITER_WIDTH:0]     halfIter;
    logic                    cap_f;
    logic                    cap_g;
    logic [1:0]              buf_wr_sel;
    logic [1:0]              buf_rd_sel;

    modport master (
        output start, blockSize, numIter,
        input  busy, done, err, CmpCounter, r, q_up, halfIter,
               cap_f, cap_g, buf_wr_sel, buf_rd_sel
    );

    modport slave (
        input  start, blockSize, numIter,
        output busy, done, err, CmpCounter, r, q_up, halfIter,
               cap_f, cap_g, buf_wr_sel, buf_rd_sel
    );

endinterface

// File: rtl/le_window_scheduler_cap_strobe_gen.sv
// le_cap_strobe_gen
// Decides whether the symbol OFFSET positions ahead of the current one
// sits on a window boundary, i.e. whether an init address must be
// captured this cycle.
// Ports:
//   active      - high only while the scheduler is in RUN
//   cmp_counter - current symbol index
//   r, q_up     - remainder and whole-window count of the block length
//   block_size  - block length K
//   strobe      - capture strobe
module le_cap_strobe_gen
    import le_window_scheduler_pkg::*;
#(
    parameter int WINDOW_WIDTH = LE_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = LE_ADDR_WIDTH,
    parameter int CMP_WIDTH    = LE_CMP_WIDTH,
    parameter int OFFSET       = 1
)(
    input  logic                    active,
    input  logic [CMP_WIDTH-1:0]    cmp_counter,
    input  logic [WINDOW_WIDTH-1:0] r,
    input  logic [3:0]              q_up,
    input  logic [ADDR_WIDTH-1:0]   block_size,
    output logic                    strobe
);

    localparam int AW = CMP_WIDTH + 1;

    logic [AW-1:0]             ahead;
    logic [WINDOW_WIDTH+3:0]   tail_start;
    logic                      at_end;
    logic                      on_boundary;
    logic                      before_tail;

    // One extra bit keeps the look-ahead index from wrapping at the top of
    // the counter range. Comparing ahead against K (rather than the counter
    // against K-OFFSET) is the same test without an unsigned subtraction.
    // When K is not a whole number of windows, the final partial window
    // begins at q_up*B; that boundary is replaced by the block-end capture.
    always_comb begin
        ahead       = AW'(cmp_counter) + AW'(OFFSET);
        tail_start  = {q_up, {WINDOW_WIDTH{1'b0}}};
        at_end      = (ahead == AW'(block_size));
        on_boundary = (ahead[WINDOW_WIDTH-1:0] == '0);
        before_tail = (ahead != AW'(tail_start));
        strobe      = 1'b0;
        if (active) begin
            if (r == '0)
                strobe = on_boundary;
            else
                strobe = at_end || (on_boundary && before_tail);
        end
    end

endmodule

// File: rtl/le_window_scheduler.sv
// le_window_scheduler
// Sequences one turbo-decode run for the soft/hard-output write path:
// symbol counter per half-iteration, r/q_up window split of the block,
// Le init-address capture strobes, window-buffer rotation and the
// half-iteration count.
// Ports:
//   clk         - clock
//   reset       - asynchronous, active-low reset; aborts a run without done
//   bus         - slave side of le_window_scheduler_if (request + outputs)
//   early_stop  - only with LE_EARLY_STOP_EN defined; ends the run after the
//                 current decoder-2 pass when high in its last gap cycle
// Build option: LE_EARLY_STOP_EN adds the early_stop input. Without it,
// exactly 2*numIter half-iterations always run.
module le_window_scheduler
    import le_window_scheduler_pkg::*;
#(
    parameter int WINDOW_WIDTH = LE_WINDOW_WIDTH,
    parameter int ADDR_WIDTH   = LE_ADDR_WIDTH,
    parameter int CMP_WIDTH    = LE_CMP_WIDTH,
    parameter int ITER_WIDTH   = LE_ITER_WIDTH
)(
    input  logic                 clk,
    input  logic                 reset,
    le_window_scheduler_if.slave bus
`ifdef LE_EARLY_STOP_EN
    ,
    input  logic                 early_stop
`endif
);

    localparam int CW1 = CMP_WIDTH + 1;
    localparam int HW  = ITER_WIDTH + 1;

    le_state_t               state_q;
    le_state_t               state_d;

    logic [ADDR_WIDTH-1:0]   blk_q;
    logic [ITER_WIDTH-1:0]   iter_q;
    logic                    err_q;
    logic [WINDOW_WIDTH-1:0] r_q;
    logic [3:0]              q_up_q;
    logic [CMP_WIDTH-1:0]    cmp_q;
    logic [HW-1:0]           half_q;
    logic [1:0]              wr_sel_q;
    logic [1:0]              gap_cnt_q;

    logic                    req_bad;
    logic                    last_sym;
    logic                    gap_last;
    logic                    last_half;
    logic                    stop_now;
    logic                    run_active;
    logic                    cap_f;
    logic                    cap_g;

    // Request checks, end-of-pass and end-of-run conditions. A bad request
    // is judged on the live inputs so the rejection lands in the very next
    // cycle without a LOAD detour.
    always_comb begin
        req_bad    = (bus.blockSize < ADDR_WIDTH'(LE_BLK_MIN)) ||
                     (bus.blockSize > ADDR_WIDTH'(LE_BLK_MAX)) ||
                     (bus.numIter == '0);
        last_sym   = (CW1'(cmp_q) + CW1'(1)) == CW1'(blk_q);
        gap_last   = (gap_cnt_q == 2'(LE_GAP_CYCLES - 1));
        last_half  = (half_q + HW'(1)) == {iter_q, 1'b0};
        run_active = (state_q == ST_RUN);
    end

    // Early stop only counts after a decoder-2 pass (odd half-iteration).
`ifdef LE_EARLY_STOP_EN
    assign stop_now = early_stop && half_q[0];
`else
    assign stop_now = 1'b0;
`endif

    // Capture strobes look one and two symbols ahead respectively.
    le_cap_strobe_gen #(
        .WINDOW_WIDTH (WINDOW_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CMP_WIDTH    (CMP_WIDTH),
        .OFFSET       (1)
    ) u_cap_f (
        .active      (run_active),
        .cmp_counter (cmp_q),
        .r           (r_q),
        .q_up        (q_up_q),
        .block_size  (blk_q),
        .strobe      (cap_f)
    );

    le_cap_strobe_gen #(
        .WINDOW_WIDTH (WINDOW_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CMP_WIDTH    (CMP_WIDTH),
        .OFFSET       (2)
    ) u_cap_g (
        .active      (run_active),
        .cmp_counter (cmp_q),
        .r           (r_q),
        .q_up        (q_up_q),
        .block_size  (blk_q),
        .strobe      (cap_g)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic. FIN always returns to IDLE, so a start coinciding
    // with done is dropped and only accepted from the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = req_bad ? ST_FIN : ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (last_sym) state_d = ST_GAP;
            ST_GAP:  if (gap_last) state_d = (last_half || stop_now) ? ST_FIN : ST_RUN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Run datapath: request capture, window split, symbol counter, gap
    // timer, half-iteration count and write-buffer rotation. The buffer
    // select steps in the cycle after each cap_f and restarts at 0 for
    // every pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q     <= '0;
            iter_q    <= '0;
            err_q     <= 1'b0;
            r_q       <= '0;
            q_up_q    <= '0;
            cmp_q     <= '0;
            half_q    <= '0;
            wr_sel_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        blk_q  <= bus.blockSize;
                        iter_q <= bus.numIter;
                        err_q  <= req_bad;
                    end
                end
                ST_LOAD: begin
                    r_q       <= blk_q[WINDOW_WIDTH-1:0];
                    q_up_q    <= blk_q[WINDOW_WIDTH+3:WINDOW_WIDTH];
                    cmp_q     <= '0;
                    half_q    <= '0;
                    wr_sel_q  <= '0;
                    gap_cnt_q <= '0;
                end
                ST_RUN: begin
                    cmp_q     <= last_sym ? '0 : cmp_q + CMP_WIDTH'(1);
                    gap_cnt_q <= '0;
                    if (cap_f)
                        wr_sel_q <= (wr_sel_q == 2'd2) ? 2'd0 : wr_sel_q + 2'd1;
                end
                ST_GAP: begin
                    cmp_q <= '0;
                    if (gap_last) begin
                        gap_cnt_q <= '0;
                        half_q    <= half_q + HW'(1);
                        wr_sel_q  <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and sequencing outputs, all derived from registered state.
    assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign bus.done       = (state_q == ST_FIN);
    assign bus.err        = (state_q == ST_FIN) && err_q;
    assign bus.CmpCounter = cmp_q;
    assign bus.r          = r_q;
    assign bus.q_up       = q_up_q;
    assign bus.halfIter   = half_q;
    assign bus.cap_f      = cap_f;
    assign bus.cap_g      = cap_g;
    assign bus.buf_wr_sel = wr_sel_q;
    assign bus.buf_rd_sel = (wr_sel_q == 2'd0) ? 2'd2 : wr_sel_q - 2'd1;

endmodule

// File: tb/tb_le_window_scheduler.sv
// tb_le_window_scheduler
// Scoreboard bench for le_window_scheduler: expected capture strobes and
// run completions are queued when a run is started and checked as the
// design produces them.
module tb_le_window_scheduler;
    import le_window_scheduler_pkg::*;

    typedef struct {
        int half;
        int cmp;
        int wr;
    } capEvent_t;

    typedef struct {
        int cyc;
        int err;
    } doneEvent_t;

    logic clk;
    logic reset;

    capEvent_t  capFQ[$];
    capEvent_t  capGQ[$];
    doneEvent_t doneQ[$];

    int testsRun;
    int failCount;
    int cyc;
    int startCyc;
    bit doneSeen;

    le_window_scheduler_if bus();

`ifdef LE_EARLY_STOP_EN
    logic early_stop;
    le_window_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .early_stop (early_stop)
    );
`else
    le_window_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index, advanced at every rising edge.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Capture positions from window arithmetic: every whole-window boundary
    // reached OFFSET symbols ahead, except the start of a partial tail
    // window, which is replaced by a capture at the block end.
    function automatic void pushCaps(input int h, input int k, input int off, input bit isF);
        int b;
        int q;
        int rem;
        int idx;
        capEvent_t e;
        b   = 1 << LE_WINDOW_WIDTH;
        q   = k / b;
        rem = k % b;
        idx = 0;
        for (int m = 1; m * b - off < k; m++) begin
            if (rem == 0 || m < q) begin
                e.half = h;
                e.cmp  = m * b - off;
                e.wr   = idx % 3;
                if (isF) capFQ.push_back(e); else capGQ.push_back(e);
                idx++;
            end
        end
        if (rem != 0) begin
            e.half = h;
            e.cmp  = k - off;
            e.wr   = idx % 3;
            if (isF) capFQ.push_back(e); else capGQ.push_back(e);
        end
    endfunction

    task automatic applyStimulus(input int k, input int n, input int halves);
        bit valid;
        doneEvent_t d;
        valid = (k >= LE_BLK_MIN) && (k <= LE_BLK_MAX) && (n != 0);
        if (valid) begin
            for (int h = 0; h < halves; h++) begin
                pushCaps(h, k, 1, 1'b1);
                pushCaps(h, k, 2, 1'b0);
            end
            d.cyc = 2 + halves * (k + 2);
            d.err = 0;
        end else begin
            d.cyc = 1;
            d.err = 1;
        end
        doneQ.push_back(d);
        @(negedge clk);
        doneSeen      = 1'b0;
        bus.blockSize = 13'(k);
        bus.numIter   = 4'(n);
        bus.start     = 1'b1;
        startCyc      = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy_cycle1", 32'(bus.busy), valid ? 32'd1 : 32'd0);
    endtask

    task automatic flushQueues();
        capFQ.delete();
        capGQ.delete();
        doneQ.delete();
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!doneSeen && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (!doneSeen) checkOutput("done_timeout", 32'd0, 32'd1);
        checkOutput("capf_left", capFQ.size(), 32'd0);
        checkOutput("capg_left", capGQ.size(), 32'd0);
        checkOutput("done_left", doneQ.size(), 32'd0);
        flushQueues();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the design emits an event.
    initial begin
        capEvent_t  ev;
        doneEvent_t dv;
        forever begin
            @(negedge clk);
            if (bus.cap_f === 1'b1) begin
                if (capFQ.size() == 0) begin
                    checkOutput("cap_f_extra", 32'(bus.CmpCounter) | 32'h8000_0000, 32'd0);
                end else begin
                    ev = capFQ.pop_front();
                    checkOutput("cap_f_cmp", 32'(bus.CmpCounter), ev.cmp);
                    checkOutput("cap_f_half", 32'(bus.halfIter), ev.half);
                    checkOutput("cap_f_wrsel", 32'(bus.buf_wr_sel), ev.wr);
                    checkOutput("cap_f_rdsel", 32'(bus.buf_rd_sel), (ev.wr == 0) ? 2 : ev.wr - 1);
                end
            end
            if (bus.cap_g === 1'b1) begin
                if (capGQ.size() == 0) begin
                    checkOutput("cap_g_extra", 32'(bus.CmpCounter) | 32'h8000_0000, 32'd0);
                end else begin
                    ev = capGQ.pop_front();
                    checkOutput("cap_g_cmp", 32'(bus.CmpCounter), ev.cmp);
                    checkOutput("cap_g_half", 32'(bus.halfIter), ev.half);
                end
            end
            if (bus.done === 1'b1) begin
                doneSeen = 1'b1;
                if (doneQ.size() == 0) begin
                    checkOutput("done_extra", 32'd1, 32'd0);
                end else begin
                    dv = doneQ.pop_front();
                    checkOutput("done_cycle", cyc - startCyc, dv.cyc);
                    checkOutput("done_err", 32'(bus.err), dv.err);
                    checkOutput("done_busy", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    initial begin
        int n;
        testsRun      = 0;
        failCount     = 0;
        doneSeen      = 1'b0;
        startCyc      = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.blockSize = '0;
        bus.numIter   = '0;
`ifdef LE_EARLY_STOP_EN
        early_stop    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_cmp", 32'(bus.CmpCounter), 32'd0);
        checkOutput("rst_half", 32'(bus.halfIter), 32'd0);
        checkOutput("rst_wrsel", 32'(bus.buf_wr_sel), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Whole windows, one iteration.
        applyStimulus(1024, 1, 2);
        waitDone(3000);

        // Partial tail window.
        applyStimulus(1100, 1, 2);
        waitDone(3000);

        // Short block, several iterations.
        applyStimulus(40, 3, 6);
        waitDone(400);

        // Smallest legal block.
        applyStimulus(4, 1, 2);
        waitDone(50);

        // Rejected requests.
        applyStimulus(2, 1, 0);
        waitDone(20);
        applyStimulus(100, 0, 0);
        waitDone(20);
        applyStimulus(6145, 1, 0);
        waitDone(20);

        // A start raised during the done cycle must be dropped.
        applyStimulus(40, 1, 2);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_reached", 32'(bus.done), 32'd1);
        bus.start     = 1'b1;
        bus.blockSize = 13'd40;
        bus.numIter   = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("ignored_start_busy", 32'(bus.busy), 32'd0);
        waitDone(1);

        // Reset in the middle of a pass.
        applyStimulus(1024, 1, 2);
        n = 0;
        while (bus.CmpCounter !== 13'd300 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_cmp300", 32'(bus.CmpCounter), 32'd300);
        #2 reset = 1'b0;
        #1;
        flushQueues();
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_cmp", 32'(bus.CmpCounter), 32'd0);
        checkOutput("abort_half", 32'(bus.halfIter), 32'd0);
        checkOutput("abort_r", 32'(bus.r), 32'd0);
        checkOutput("abort_qup", 32'(bus.q_up), 32'd0);
        checkOutput("abort_wrsel", 32'(bus.buf_wr_sel), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(40, 1, 2);
        waitDone(200);

`ifdef LE_EARLY_STOP_EN
        // Early stop after the first decoder-2 pass.
        early_stop = 1'b1;
        applyStimulus(40, 4, 2);
        waitDone(400);
        early_stop = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
